// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the BNN parameter loader.
// Defaults describe the production neuron array.
package bnn_pkg;

  localparam int NEURONS    = 4;
  localparam int INPUTS     = 8;
  localparam int BIAS_BITS  = 3;
  localparam int TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/param_loader_if.sv
// Byte stream in, serial chain out, plus loader status.
// master = controller/feeder side, slave = loader side.
interface param_loader_if;

  logic       start;
  logic       abort;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       setup;
  logic       param_out;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output abort,
    output data_in,
    output data_valid,
    input  data_ready,
    input  setup,
    input  param_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  data_in,
    input  data_valid,
    output data_ready,
    output setup,
    output param_out,
    output busy,
    output done
  );

endinterface

// File: rtl/byte_serializer.sv
// Byte buffer feeding the loader one chain bit per cycle, MSB first.
// The last byte is trimmed to the bits the chain still needs.
module byte_serializer #(
  parameter int RW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic [RW-1:0] rem,
  input  logic [7:0]    data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic          emit,
  output logic          bit_out
);

  logic [7:0] buf_q, buf_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] vcnt_q, vcnt_d;
  logic       full_q, full_d;
  logic       last;
  logic       accept;
  logic [3:0] in_flight;
  logic [3:0] vcnt_new;
  int         avail;

  // Bits still owed by the buffer decide readiness and next byte size
  always_comb begin
    last       = ({1'b0, idx_q} == (vcnt_q - 4'd1));
    in_flight  = full_q ? (vcnt_q - {1'b0, idx_q}) : 4'd0;
    avail      = int'(rem) - int'(in_flight);
    vcnt_new   = (avail >= 8) ? 4'd8 : 4'(avail);
    data_ready = active && (!full_q || last) && (avail > 0);
    accept     = data_valid && data_ready;
    emit       = active && full_q;
    bit_out    = buf_q[7];
  end

  // Shift out one bit per emit; a new byte may land on the last bit
  always_comb begin
    buf_d  = buf_q;
    idx_d  = idx_q;
    vcnt_d = vcnt_q;
    full_d = full_q;
    if (!active) begin
      idx_d  = 3'd0;
      vcnt_d = 4'd0;
      full_d = 1'b0;
    end else begin
      if (emit) begin
        buf_d = {buf_q[6:0], 1'b0};
        idx_d = idx_q + 3'd1;
        if (last) begin
          idx_d  = 3'd0;
          full_d = 1'b0;
        end
      end
      if (accept) begin
        buf_d  = data_in;
        idx_d  = 3'd0;
        vcnt_d = vcnt_new;
        full_d = 1'b1;
      end
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= 8'd0;
      idx_q  <= 3'd0;
      vcnt_q <= 4'd0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      idx_q  <= idx_d;
      vcnt_q <= vcnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/param_loader.sv
// Serial parameter chain feeder: FSM, remaining-bit counter and
// registered chain outputs around a byte_serializer.
module param_loader #(
  parameter int NEURONS   = bnn_pkg::NEURONS,
  parameter int INPUTS    = bnn_pkg::INPUTS,
  parameter int BIAS_BITS = bnn_pkg::BIAS_BITS
) (
  input logic           clk,
  input logic           rst_n,
  param_loader_if.slave bus
);

  import bnn_pkg::*;

  localparam int TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int RW         = $clog2(TOTAL_BITS + 1);

  state_e        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          setup_q, setup_d;
  logic          po_q, po_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          active;
  logic          emit;
  logic          bit_out;

  assign active = (state_q == LOAD) && !bus.abort;

  byte_serializer #(
    .RW(RW)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (active),
    .rem        (rem_q),
    .data_in    (bus.data_in),
    .data_valid (bus.data_valid),
    .data_ready (bus.data_ready),
    .emit       (emit),
    .bit_out    (bit_out)
  );

  // Next state; abort wins over start, param_out holds when idle
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    setup_d = 1'b0;
    po_d    = po_q;
    if (bus.abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = LOAD;
            rem_d   = RW'(TOTAL_BITS);
          end
        end
        LOAD: begin
          if (emit) begin
            setup_d = 1'b1;
            po_d    = bit_out;
            rem_d   = rem_q - RW'(1);
          end else if (rem_q == '0) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == LOAD);
    done_d = (state_d == DONE);
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      setup_q <= 1'b0;
      po_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      setup_q <= setup_d;
      po_q    <= po_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.setup     = setup_q;
  assign bus.param_out = po_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
